// File: rtl/temporal_pixel_window.sv
// rtl/temporal_pixel_window.sv - gathers the same pixel address across NUM_FRAMES consecutive frames
// One wide word per address holds the stored frames; each accepted pixel reads it, then writes it back shifted.
module temporal_pixel_window #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int NUM_FRAMES   = 7,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pixel_valid,
  input  logic [PIXEL_WIDTH-1:0]          pixel_in,
  input  logic                            sof,
  output logic [PIXEL_WIDTH*NUM_FRAMES-1:0] pixels_out,
  output logic                            out_valid,
  output logic                            primed,
  output logic                            frame_err
);
  localparam int MEM_W = PIXEL_WIDTH * (NUM_FRAMES - 1);
  localparam int WIN_W = PIXEL_WIDTH * NUM_FRAMES;
  localparam int AW    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int FDW   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(FRAME_PIXELS - 1);
  localparam logic [FDW-1:0] FD_MAX    = FDW'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {WAIT_SOF, IN_FRAME, FRAME_DONE} state_t;

  state_t               state_q;
  logic [AW-1:0]        addr_q;
  logic [FDW-1:0]       frames_done_q;
  logic                 frame_err_q;

  logic                 s1_valid_q;
  logic                 s1_primed_q;
  logic [PIXEL_WIDTH-1:0] s1_pixel_q;
  logic [AW-1:0]        s1_addr_q;
  logic [MEM_W-1:0]     rd_data_q;
  logic [WIN_W-1:0]     pixels_out_q;
  logic                 out_valid_q;

  logic [MEM_W-1:0]     mem_q [FRAME_PIXELS];

  logic                 accept_d;
  logic                 short_err_d;
  logic [AW-1:0]        pix_addr_d;
  logic [WIN_W-1:0]     window_d;

  assign accept_d    = pixel_valid && (sof || state_q == IN_FRAME);
  assign short_err_d = pixel_valid && sof && state_q == IN_FRAME && addr_q != '0;
  assign pix_addr_d  = sof ? '0 : addr_q;
  assign window_d    = {s1_pixel_q, rd_data_q};

  assign primed     = (frames_done_q == FD_MAX);
  assign frame_err  = frame_err_q;
  assign pixels_out = pixels_out_q;
  assign out_valid  = out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_SOF;
      addr_q        <= '0;
      frames_done_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (pixel_valid) begin
        if (sof) begin
          if (short_err_d) begin
            frame_err_q   <= 1'b1;
            frames_done_q <= '0;
          end
          state_q <= IN_FRAME;
          addr_q  <= AW'(1);
        end else if (state_q == IN_FRAME) begin
          if (addr_q == LAST_ADDR) begin
            state_q <= FRAME_DONE;
            addr_q  <= '0;
            if (!primed) frames_done_q <= frames_done_q + FDW'(1);
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end else if (state_q == FRAME_DONE) begin
          frame_err_q <= 1'b1;
          state_q     <= WAIT_SOF;
        end
      end
    end
  end

  // A pixel that breaks the previous frame starts a window mixing frames, so it never reports valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_primed_q  <= 1'b0;
      s1_pixel_q   <= '0;
      s1_addr_q    <= '0;
      pixels_out_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      s1_valid_q  <= accept_d;
      s1_primed_q <= accept_d && primed && !short_err_d;
      if (accept_d) begin
        s1_pixel_q <= pixel_in;
        s1_addr_q  <= pix_addr_d;
      end
      out_valid_q <= s1_valid_q && s1_primed_q;
      if (s1_valid_q) pixels_out_q <= window_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_d) rd_data_q <= mem_q[pix_addr_d];
    if (s1_valid_q) mem_q[s1_addr_q] <= window_d[PIXEL_WIDTH +: MEM_W];
  end
endmodule

// File: tb/tb_temporal_pixel_window.sv
// tb/tb_temporal_pixel_window.sv - bench for temporal_pixel_window with FRAME_PIXELS=4, NUM_FRAMES=7
module tb_temporal_pixel_window;
  localparam int PW = 8;
  localparam int NF = 7;
  localparam int FP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pixel_valid;
  logic [PW-1:0] pixel_in;
  logic          sof;
  logic [PW*NF-1:0] pixels_out;
  logic          out_valid;
  logic          primed;
  logic          frame_err;

  temporal_pixel_window #(.PIXEL_WIDTH(PW), .NUM_FRAMES(NF), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .pixel_in(pixel_in), .sof(sof),
    .pixels_out(pixels_out), .out_valid(out_valid), .primed(primed), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          s;
    logic [7:0]    pix;
    logic          ov;
    logic          full;
    logic [55:0]   win;
    logic          pr;
  } vec_t;

  typedef struct {
    logic          acc;
    logic          ov;
    logic          full;
    logic [55:0]   win;
    logic [7:0]    pix;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic [7:0] exp_top = 8'h00;

  function automatic logic [7:0] pix_of(input int f, input int a);
    return 8'((16 * f + a) & 255);
  endfunction

  function automatic logic [55:0] win_of(input int f, input int a);
    logic [55:0] w;
    for (int k = 0; k < NF; k++) w[k*8 +: 8] = pix_of(f - 6 + k, a);
    return w;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  task automatic add_vec(input logic v, input logic s, input logic [7:0] pix, input logic ov,
                         input logic full, input logic [55:0] win, input logic pr);
    vec_t r;
    r.v = v; r.s = s; r.pix = pix; r.ov = ov; r.full = full; r.win = win; r.pr = pr;
    vecs.push_back(r);
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] pix, input logic acc,
                      input logic ov, input logic full, input logic [55:0] win,
                      input logic err, input logic pr);
    exp_t e;
    pixel_valid = v;
    sof         = s;
    pixel_in    = pix;
    e.acc = acc; e.ov = ov; e.full = full; e.win = win; e.pix = pix;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    chk("frame_err", 64'(frame_err), 64'(err));
    chk("primed", 64'(primed), 64'(pr));
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      chk("out_valid", 64'(out_valid), 64'(e.ov));
      if (e.acc) exp_top = e.pix;
      chk("current_slot", 64'(pixels_out[55:48]), 64'(exp_top));
      if (e.full) chk("window", 64'(pixels_out), 64'(e.win));
    end
  endtask

  task automatic send_frame(input int f, input logic pr0, input logic pr_end, input logic full);
    for (int a = 0; a < FP; a++)
      step(1'b1, a == 0, pix_of(f, a), 1'b1, pr0, full, win_of(f, a), 1'b0,
           (a == FP - 1) ? pr_end : pr0);
  endtask

  task automatic idle(input logic pr);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 56'h0, 1'b0, pr);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_pixels_out"}, 64'(pixels_out), 64'h0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'h0);
    chk({tag, "_primed"}, 64'(primed), 64'h0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // Frames 0..8 back-to-back, then frame 9 with idle gaps where sof is high but valid is low.
    for (int f = 0; f < 9; f++)
      for (int a = 0; a < FP; a++)
        add_vec(1'b1, a == 0, pix_of(f, a), f >= 6, f >= 6, win_of(f, a),
                (f > 5) || (f == 5 && a == FP - 1));
    for (int a = 0; a < FP; a++) begin
      add_vec(1'b1, a == 0, pix_of(9, a), 1'b1, 1'b1, win_of(9, a), 1'b1);
      add_vec(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 56'h0, 1'b1);
    end

    rst_n = 1'b0; pixel_valid = 1'b0; sof = 1'b0; pixel_in = '0;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_zero_outputs("post_reset");

    foreach (vecs[i])
      step(vecs[i].v, vecs[i].s, vecs[i].pix, vecs[i].v, vecs[i].ov, vecs[i].full,
           vecs[i].win, 1'b0, vecs[i].pr);

    // Short frame: sof lands at addr 2 of frame 10.
    step(1'b1, 1'b1, pix_of(10, 0), 1'b1, 1'b1, 1'b1, win_of(10, 0), 1'b0, 1'b1);
    step(1'b1, 1'b0, pix_of(10, 1), 1'b1, 1'b1, 1'b1, win_of(10, 1), 1'b0, 1'b1);
    step(1'b1, 1'b1, pix_of(11, 0), 1'b1, 1'b0, 1'b0, 56'h0, 1'b1, 1'b0);
    for (int a = 1; a < FP; a++)
      step(1'b1, 1'b0, pix_of(11, a), 1'b1, 1'b0, 1'b0, 56'h0, 1'b0, 1'b0);
    for (int f = 12; f <= 16; f++) send_frame(f, 1'b0, f == 16, 1'b0);
    send_frame(17, 1'b1, 1'b1, 1'b1);

    // Missing sof after a complete frame: one error, second stray pixel silently dropped.
    step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 56'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'hEF, 1'b0, 1'b0, 1'b0, 56'h0, 1'b0, 1'b1);
    send_frame(18, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of frame 19.
    step(1'b1, 1'b1, pix_of(19, 0), 1'b1, 1'b1, 1'b1, win_of(19, 0), 1'b0, 1'b1);
    step(1'b1, 1'b0, pix_of(19, 1), 1'b1, 1'b1, 1'b1, win_of(19, 1), 1'b0, 1'b1);
    pixel_valid = 1'b1; sof = 1'b0; pixel_in = pix_of(19, 2);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    pixel_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.delete();
    exp_top = 8'h00;
    step(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 56'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h56, 1'b0, 1'b0, 1'b0, 56'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h57, 1'b0, 1'b0, 1'b0, 56'h0, 1'b0, 1'b0);
    for (int f = 20; f <= 25; f++) send_frame(f, 1'b0, f == 25, 1'b0);
    send_frame(26, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
